// File: rtl/div_unit.sv
// Restoring 32-step integer divider behind the EX-stage divide handshake.
// Returns {remainder, quotient} with a one-cycle divide-by-zero shortcut.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    signed_i,
  input  logic                    annul_i,
  input  logic [DATA_WIDTH-1:0]   dividend_i,
  input  logic [DATA_WIDTH-1:0]   divisor_i,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic                    ready_o,
  output logic                    busy_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DBZ,
    S_ON,
    S_END
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] quo;
  logic [DW-1:0] dvs;
  logic          sgn;
  logic          neg_a;
  logic          neg_b;

  logic          accept;
  logic          last;
  logic [DW:0]   trial;
  logic          fits;
  logic [DW-1:0] rem_n;
  logic [DW-1:0] quo_n;
  logic [DW-1:0] q_fix;
  logic [DW-1:0] r_fix;
  logic [DW-1:0] raw;

  assign accept = (state == S_IDLE) && start_i && !annul_i;
  assign last   = (cnt == CW'(DW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_n = (divisor_i == '0) ? S_DBZ : S_ON;
      end
      S_ON: begin
        if (annul_i)   state_n = S_IDLE;
        else if (last) state_n = S_END;
      end
      S_DBZ: begin
        state_n = annul_i ? S_IDLE : S_END;
      end
      S_END: begin
        if (annul_i || !start_i)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial = {rem, quo[DW-1]};
    fits  = (trial >= {1'b0, dvs});
    rem_n = fits ? (trial[DW-1:0] - dvs) : trial[DW-1:0];
    quo_n = {quo[DW-2:0], fits};
    q_fix = (sgn && (neg_a ^ neg_b)) ? -quo_n : quo_n;
    r_fix = (sgn && neg_a) ? -rem_n : rem_n;
    raw   = (sgn && neg_a) ? -quo : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sgn      <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      result_o <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          sgn   <= signed_i;
          neg_a <= signed_i & dividend_i[DW-1];
          neg_b <= signed_i & divisor_i[DW-1];
          quo   <= (signed_i && dividend_i[DW-1]) ?
                   -dividend_i : dividend_i;
          dvs   <= (signed_i && divisor_i[DW-1]) ?
                   -divisor_i : divisor_i;
          rem   <= '0;
          cnt   <= '0;
        end
        (state == S_ON && !annul_i): begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (last) result_o <= {r_fix, q_fix};
        end
        (state == S_DBZ && !annul_i): begin
          result_o <= {raw, {DW{1'b1}}};
        end
        default: ;
      endcase
    end
  end

  assign ready_o = !rst && (state == S_END) && !annul_i;
  assign busy_o  = !rst && (accept ||
                   (state == S_ON) || (state == S_DBZ));

endmodule
